// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial 2-bit-slice comparator controller.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned SLICE_W = 2;
  localparam int unsigned RES_W   = 3;

  // Result encoding, packed as {eq, lt, gt}
  localparam logic [RES_W-1:0] RES_NONE = 3'b000;
  localparam logic [RES_W-1:0] RES_EQ   = 3'b100;
  localparam logic [RES_W-1:0] RES_LT   = 3'b010;
  localparam logic [RES_W-1:0] RES_GT   = 3'b001;

endpackage

// File: rtl/cmp2_slice.sv
// Gate-level 2-bit unsigned magnitude comparator; exactly one output is high.
module cmp2_slice
  import cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               eq_c,
  output logic               lt_c,
  output logic               gt_c
);

  logic hi_eq_c;
  logic lo_eq_c;

  assign hi_eq_c = a[1] ~^ b[1];
  assign lo_eq_c = a[0] ~^ b[0];

  // MSB decides unless equal, then the LSB decides
  assign eq_c = hi_eq_c & lo_eq_c;
  assign gt_c = (a[1] & ~b[1]) | (hi_eq_c & a[0] & ~b[0]);
  assign lt_c = (~a[1] & b[1]) | (hi_eq_c & ~a[0] & b[0]);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Compares two WIDTH-bit unsigned operands by stepping one 2-bit comparator
// slice from the MSB pair downward, stopping at the first unequal pair.
module serial_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SEL_W  = IDX_W + 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SEL_W-1:0]   sel_c;
  logic [SLICE_W-1:0] sa_c;
  logic [SLICE_W-1:0] sb_c;
  logic               s_eq_c;
  logic               s_lt_c;
  logic               s_gt_c;

  // Bit offset of the current pair is idx*2
  assign sel_c = {idx_q, 1'b0};
  assign sa_c  = a_q[sel_c +: SLICE_W];
  assign sb_c  = b_q[sel_c +: SLICE_W];

  cmp2_slice u_slice (
    .a    (sa_c),
    .b    (sb_c),
    .eq_c (s_eq_c),
    .lt_c (s_lt_c),
    .gt_c (s_gt_c)
  );

  // Next-state, counter, operand capture and result update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_W'(NSLICE - 1);
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!s_eq_c) begin
          res_d   = s_lt_c ? RES_LT : (s_gt_c ? RES_GT : RES_NONE);
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          // Last pair equal: the whole operands are equal; idx never wraps
          res_d   = RES_EQ;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= RES_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = res_q[2];
  assign lt   = res_q[1];
  assign gt   = res_q[0];

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl; expected results and done cycles go
// into a scoreboard queue at start time and are checked when done fires.
module tb_serial_compare_ctrl;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_LT = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       eq;
  logic       lt;
  logic       gt;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t sb[$];

  serial_compare_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .lt    (lt),
    .gt    (gt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'({eq, lt, gt}), 32'(e.res));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge where done should be high
  task automatic go(input logic [7:0] av, input logic [7:0] bv, input int k,
                    input logic [2:0] res);
    int cnt;
    exp_t e;
    cnt = 0;
    a = av;
    b = bv;
    start = 1'b1;
    e.res = res;
    e.cyc = cyc + 1 + k;
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (busy) cnt++;
      else break;
    end
    chk("busy_cycles", 32'(cnt), 32'(k));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("reset_outputs", 32'({busy, done, eq, lt, gt}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_outputs", 32'({busy, done, eq, lt, gt}), 32'd0);

    // MSB pair differs: one slice
    go(8'hC0, 8'h40, 1, R_GT);
    drain();
    repeat (2) @(negedge clk);
    chk("hold_gt", 32'({eq, lt, gt}), 32'(R_GT));
    chk("idle_after_done", 32'({busy, done}), 32'd0);

    // Equal operands: full scan
    go(8'hA5, 8'hA5, 4, R_EQ);
    drain();
    repeat (2) @(negedge clk);
    chk("hold_eq", 32'({eq, lt, gt}), 32'(R_EQ));

    // Difference only in the LSB pair
    go(8'h12, 8'h13, 4, R_LT);
    drain();
    repeat (2) @(negedge clk);

    // First op with a start pulse mid-SCAN that must be ignored
    begin
      exp_t e;
      a = 8'h01;
      b = 8'h02;
      start = 1'b1;
      e.res = R_LT;
      e.cyc = cyc + 1 + 4;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 8'hFF;
      b = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_mid_scan", 32'(busy), 32'd1);
      for (int i = 0; i < 20 && !done; i++) @(negedge clk);
      chk("first_done_seen", 32'(done), 32'd1);
      chk("first_lt", 32'({eq, lt, gt}), 32'(R_LT));
      // Back-to-back start accepted in DONE
      a = 8'hFF;
      b = 8'h00;
      start = 1'b1;
      e.res = R_GT;
      e.cyc = cyc + 1 + 1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 32'({busy, done}), 32'b10);
      chk("held_between_dones", 32'({eq, lt, gt}), 32'(R_LT));
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'd1);
      drain();
      repeat (2) @(negedge clk);
    end

    // Reset during the second SCAN cycle discards the operation
    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({busy, done, eq, lt, gt}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_done_after_reset", 32'({busy, done, eq, lt, gt}), 32'd0);

    go(8'h80, 8'h7F, 1, R_GT);
    drain();
    repeat (2) @(negedge clk);
    chk("final_hold_gt", 32'({eq, lt, gt}), 32'(R_GT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
